// File: rtl/ddr2_local_responder_pkg.sv
// Shared definitions for the DDR2 local-interface responder.
//   state_t          : responder FSM encoding (IDLE / WR_BURST / REFRESH)
//   LOCAL_*          : default widths of the local interface
//   beat_index()     : converts a byte-style cmd_addr into a beat index
package ddr2_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_BURST = 2'd1,
    ST_REFRESH  = 2'd2
  } state_t;

  localparam int LOCAL_DATA_W     = 144;
  localparam int LOCAL_ADDR_W     = 32;
  localparam int LOCAL_ADDR_SHIFT = 4;

  // cmd_addr counts in sub-beat units; one beat spans 2**shift of them.
  function automatic logic [63:0] beat_index(input logic [63:0] addr,
                                             input int unsigned shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/ddr2_local_responder_if.sv
// Local-side bus between a DDR2 controller driver (master) and a responder
// (slave).
//   master drives : burst_begin, wr_req, rd_req, cmd_addr, wdata
//   slave drives  : ready, rdata_valid, rdata, protocol_err
interface ddr2_local_if #(
  parameter int DATA_W = ddr2_if_pkg::LOCAL_DATA_W,
  parameter int ADDR_W = ddr2_if_pkg::LOCAL_ADDR_W
);
  logic              burst_begin;
  logic              wr_req;
  logic              rd_req;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              protocol_err;

  modport master (
    output burst_begin, wr_req, rd_req, cmd_addr, wdata,
    input  ready, rdata_valid, rdata, protocol_err
  );

  modport slave (
    input  burst_begin, wr_req, rd_req, cmd_addr, wdata,
    output ready, rdata_valid, rdata, protocol_err
  );
endinterface

// File: rtl/ddr2_rd_lat_pipe.sv
// Fixed-latency delay line for accepted read commands.
//   clk       : clock
//   flush     : synchronous clear of all valid bits
//   in_valid  : read command accepted this cycle
//   in_idx    : beat index of that command
//   out_valid : command has spent DEPTH cycles in the line
//   out_idx   : its beat index
module ddr2_rd_lat_pipe #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] vld;
  logic [IDX_W-1:0] idx [DEPTH];

  always_ff @(posedge clk) begin
    if (flush) vld <= '0;
    else       vld <= {vld[DEPTH-2:0], in_valid};
  end

  // The index payload is only meaningful alongside its valid bit, so it
  // shifts freely without a clear.
  always_ff @(posedge clk) begin
    idx[0] <= in_idx;
    for (int i = 1; i < DEPTH; i++) idx[i] <= idx[i-1];
  end

  assign out_valid = vld[DEPTH-1];
  assign out_idx   = idx[DEPTH-1];

endmodule

// File: rtl/ddr2_local_responder.sv
// RAM-backed responder for the DDR2 controller local interface: accepts
// write bursts and read commands, returns read bursts after a fixed
// latency and periodically stalls for refresh.
//   clk : clock, rising edge
//   rst : synchronous reset, active-high
//   bus : ddr2_local_if slave (requests in; ready/rdata_valid/rdata/
//         protocol_err out)
module ddr2_local_responder
  import ddr2_if_pkg::*;
#(
  parameter int DATA_W         = LOCAL_DATA_W,
  parameter int ADDR_W         = LOCAL_ADDR_W,
  parameter int ADDR_SHIFT     = LOCAL_ADDR_SHIFT,
  parameter int MEM_AW         = 8,
  parameter int BURST_LEN      = 2,
  parameter int RD_LAT         = 4,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_BUSY   = 4
) (
  input logic         clk,
  input logic         rst,
  ddr2_local_if.slave bus
);

  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  localparam int BUSY_W = $clog2(REFRESH_BUSY + 1);
  localparam int RCNT_W = $clog2(REFRESH_PERIOD);
  localparam int DEPTH  = 1 << MEM_AW;

  state_t              state, state_n;
  logic [CNT_W-1:0]    beat_cnt, beat_cnt_n;
  logic [CNT_W-1:0]    hold_cnt, hold_n;
  logic [BUSY_W-1:0]   busy_cnt, busy_n;
  logic [MEM_AW-1:0]   wr_ptr, wr_ptr_n;
  logic [RCNT_W-1:0]   refresh_cnt;
  logic                refresh_pending, pending_n, pend_now, ref_expire;
  logic                take_refresh;
  logic                ready_q, ready_n;
  logic                perr_q, perr_n;
  logic                mem_we;
  logic [MEM_AW-1:0]   mem_waddr;
  logic                push;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [MEM_AW-1:0]   cmd_idx;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                pipe_valid;
  logic [MEM_AW-1:0]   pipe_idx;
  logic [CNT_W-1:0]    seq_cnt;
  logic [MEM_AW-1:0]   seq_idx;
  logic                beat_fire;
  logic [MEM_AW-1:0]   rd_idx;
  logic                rdata_valid_q;
  logic [DATA_W-1:0]   rdata_q;

  assign cmd_addr   = bus.cmd_addr;
  assign cmd_idx    = MEM_AW'(beat_index(64'(cmd_addr), ADDR_SHIFT));
  assign ref_expire = (refresh_cnt == RCNT_W'(REFRESH_PERIOD - 1));
  assign pend_now   = refresh_pending | ref_expire;

  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    wr_ptr_n   = wr_ptr;
    busy_n     = busy_cnt;
    perr_n     = perr_q;
    hold_n     = (hold_cnt != '0) ? hold_cnt - CNT_W'(1) : hold_cnt;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr;
    push       = 1'b0;

    case (state)
      ST_IDLE: if (ready_q) begin
        if (bus.wr_req && bus.burst_begin) begin
          mem_we    = 1'b1;
          mem_waddr = cmd_idx;
          wr_ptr_n  = cmd_idx + MEM_AW'(1);
          if (BURST_LEN > 1) begin
            state_n    = ST_WR_BURST;
            beat_cnt_n = CNT_W'(1);
          end
          // A simultaneous read loses to the write and is flagged.
          if (bus.rd_req) perr_n = 1'b1;
        end else begin
          if (bus.wr_req) perr_n = 1'b1;
          if (bus.rd_req) begin
            push   = 1'b1;
            hold_n = CNT_W'(BURST_LEN - 1);
          end
        end
      end
      ST_WR_BURST: if (ready_q) begin
        if (bus.rd_req || bus.burst_begin) perr_n = 1'b1;
        if (bus.wr_req && !bus.burst_begin) begin
          mem_we     = 1'b1;
          mem_waddr  = wr_ptr;
          wr_ptr_n   = wr_ptr + MEM_AW'(1);
          beat_cnt_n = beat_cnt + CNT_W'(1);
          if (beat_cnt == CNT_W'(BURST_LEN - 1)) begin
            state_n    = ST_IDLE;
            beat_cnt_n = '0;
          end
        end
      end
      ST_REFRESH: begin
        if (busy_cnt == '0) state_n = ST_IDLE;
        else                busy_n  = busy_cnt - BUSY_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase

    // Refresh is entered on the same edge the FSM would settle in IDLE
    // with no read hold, so a completing burst rolls straight into it.
    take_refresh = (state_n == ST_IDLE) && (hold_n == '0) && pend_now;
    if (take_refresh) begin
      state_n = ST_REFRESH;
      busy_n  = BUSY_W'(REFRESH_BUSY - 1);
    end
    pending_n = pend_now & ~take_refresh;
    ready_n   = (state_n != ST_REFRESH) && (hold_n == '0);
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      beat_cnt        <= '0;
      wr_ptr          <= '0;
      hold_cnt        <= '0;
      busy_cnt        <= '0;
      refresh_cnt     <= '0;
      refresh_pending <= 1'b0;
      ready_q         <= 1'b0;
      perr_q          <= 1'b0;
    end else begin
      state           <= state_n;
      beat_cnt        <= beat_cnt_n;
      wr_ptr          <= wr_ptr_n;
      hold_cnt        <= hold_n;
      busy_cnt        <= busy_n;
      refresh_cnt     <= ref_expire ? '0 : refresh_cnt + RCNT_W'(1);
      refresh_pending <= pending_n;
      ready_q         <= ready_n;
      perr_q          <= perr_n;
    end
  end

  // NOTE: the RAM has no reset; its contents survive rst by design and a
  // reset branch would prevent block-RAM mapping.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= bus.wdata;
  end

  ddr2_rd_lat_pipe #(
    .DEPTH (RD_LAT),
    .IDX_W (MEM_AW)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (rst),
    .in_valid  (push),
    .in_idx    (cmd_idx),
    .out_valid (pipe_valid),
    .out_idx   (pipe_idx)
  );

  // Beat sequencer: each pipe entry becomes BURST_LEN consecutive beats.
  // The read hold guarantees a new entry never arrives mid-expansion.
  assign beat_fire = pipe_valid | (seq_cnt != '0);
  assign rd_idx    = pipe_valid ? pipe_idx : seq_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_cnt       <= '0;
      seq_idx       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      rdata_valid_q <= beat_fire;
      if (beat_fire) rdata_q <= mem[rd_idx];
      if (pipe_valid) begin
        seq_cnt <= CNT_W'(BURST_LEN - 1);
        seq_idx <= pipe_idx + MEM_AW'(1);
      end else if (seq_cnt != '0) begin
        seq_cnt <= seq_cnt - CNT_W'(1);
        seq_idx <= seq_idx + MEM_AW'(1);
      end
    end
  end

  assign bus.ready        = ready_q;
  assign bus.rdata_valid  = rdata_valid_q;
  assign bus.rdata        = rdata_q;
  assign bus.protocol_err = perr_q;

endmodule
